// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: accepts a byte, drives the serializer and
// muxes start/data/parity/stop bits onto the line, one bit per baud clock.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic [DATA_WIDTH-1:0] P_DATA_lat,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  ser_err
);

  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int STOP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [STOP_W-1:0]   r_stop_cnt;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_busy;
  logic                r_ser_err;
  logic                w_last_stop;
  logic                w_accept;
  logic                w_watchdog;

  assign w_last_stop = (r_state == S_STOP) && (r_stop_cnt == STOP_W'(STOP_BITS - 1));
  assign w_accept    = Data_Valid && ((r_state == S_IDLE) || w_last_stop);
  // Last data slot reached without the serializer flagging completion.
  assign w_watchdog  = (r_state == S_DATA) && !ser_done &&
                       (r_bit_cnt == CNT_W'(DATA_WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    ser_load     = 1'b0;
    ser_en       = 1'b0;
    TX_OUT       = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_START;
      end
      S_START: begin
        ser_load     = 1'b1;
        ser_en       = 1'b1;
        TX_OUT       = 1'b0;
        w_state_next = S_DATA;
      end
      S_DATA: begin
        ser_en = 1'b1;
        TX_OUT = ser_data;
        if (ser_done)        w_state_next = r_par_en ? S_PARITY : S_STOP;
        else if (w_watchdog) w_state_next = S_STOP;
      end
      S_PARITY: begin
        TX_OUT       = r_par_bit;
        w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_last_stop) w_state_next = w_accept ? S_START : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_busy     <= 1'b0;
      r_ser_err  <= 1'b0;
      P_DATA_lat <= '0;
    end else begin
      r_state   <= w_state_next;
      r_busy    <= (w_state_next != S_IDLE);
      r_ser_err <= w_watchdog;
      if (w_accept) begin
        P_DATA_lat <= P_DATA;
        r_par_en   <= PAR_EN;
        r_par_bit  <= (^P_DATA) ^ PAR_TYP;
      end
      if (r_state == S_START)     r_bit_cnt <= '0;
      else if (r_state == S_DATA) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (r_state == S_STOP) r_stop_cnt <= r_stop_cnt + 1'b1;
      else                   r_stop_cnt <= '0;
    end
  end

  assign Busy    = r_busy;
  assign ser_err = r_ser_err;

endmodule
